ewb_mem_arbiter: RTL
====================

Name: ewb_mem_arbiter

Overview:
Sequences the L2 eviction write buffer (EWB) against physical memory. Shares the single pmem port between L2 read misses and EWB drains. Serves read misses directly from the EWB when the line is still queued. Sits between the L2 cache controller, the EWB and the pmem/cacheline adaptor.

Parameters:
WIDTH, 256, cacheline width in bits
MAX_READ_STREAK, 4, consecutive pmem reads allowed while EWB non-empty before one drain is forced
STREAK_W, 3, width of streak counter (must hold MAX_READ_STREAK)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
l2_read  in  1  L2 read-miss request; held high until l2_resp
l2_address  in  32  miss address
l2_rdata  out  WIDTH  fill line
l2_resp  out  1  one-cycle completion pulse
ewb_empty  in  1  EWB empty
ewb_full  in  1  EWB full
ewb_head_data  in  WIDTH  EWB head line
ewb_head_addr  in  32  EWB head address
ewb_yumi  out  1  dequeue EWB head, one-cycle pulse
ewb_tag_check  out  1  enable EWB associative lookup
ewb_tag  out  27  lookup tag, address[31:5]
ewb_hit  in  1  lookup hit, combinational from ewb_tag_check/ewb_tag
ewb_hit_data  in  WIDTH  lookup data
pmem_read  out  1  memory read request
pmem_write  out  1  memory write request
pmem_address  out  32  line-aligned, bits [4:0] = 0
pmem_wdata  out  WIDTH  write line
pmem_rdata  in  WIDTH  read line
pmem_resp  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (rst low, async): state IDLE, streak=0, pending_rd=0, latched addr/data=0. All outputs 0 while reset is asserted and in IDLE. An in-flight pmem request is dropped immediately; the EWB entry is not dequeued.
- States: IDLE, CHECK, FWD, READ, WRITE. Exactly one of pmem_read/pmem_write is high, and only in READ or WRITE respectively.
- IDLE:
  - l2_read=1: latch l2_address, go to CHECK. Read beats drain on simultaneous requests.
  - Else if !ewb_empty: go to WRITE.
  - Else stay in IDLE.
- CHECK (1 cycle): ewb_tag_check=1, ewb_tag=latched_addr[31:5].
  - ewb_hit=1: register ewb_hit_data, go to FWD.
  - Else if ewb_full, or (streak==MAX_READ_STREAK and !ewb_empty): set pending_rd=1, go to WRITE.
  - Else go to READ.
- FWD (1 cycle): l2_resp=1, l2_rdata=registered hit data. Go to IDLE. No pmem traffic; streak unchanged.
- READ: pmem_read=1, pmem_address={latched_addr[31:5],5'b0}.
  - On pmem_resp: l2_resp=1 and l2_rdata=pmem_rdata in the same cycle.
  - streak increments (saturating) if !ewb_empty, else streak clears.
  - Go to IDLE.
- WRITE: pmem_write=1, pmem_address={ewb_head_addr[31:5],5'b0}, pmem_wdata=ewb_head_data.
  - On pmem_resp: ewb_yumi=1 (same cycle), streak=0.
  - Then: pending_rd=1 → clear it and go to CHECK (re-lookup required, since other entries may match). pending_rd=0 → go to IDLE.
- Coherence: the head stays in the EWB until its write completes, so a read to a line being drained always hits in CHECK. ewb_yumi is never asserted when ewb_empty=1.
- Minimum latency:
  - EWB hit: l2_resp 2 cycles after IDLE sees l2_read.
  - Miss: 2 cycles plus memory latency.
- l2_resp, ewb_yumi and ewb_tag_check are 0 in every state/condition not listed above.
- l2_address is sampled only in IDLE; changes mid-transaction are ignored.

Decomposition:
- Package rv32i_types: arb_state_t enum {IDLE, CHECK, FWD, READ, WRITE}; localparams LINE_OFFSET=5, TAG_W=27.
- Sub-modules: none. One FSM (state register plus next-state/output combinational blocks) and the streak counter.

Test Plan:
- Reset, idle EWB empty, l2_read addr 0x0000_1234 → pmem_read with pmem_address 0x0000_1220; pmem_resp with rdata 0xA5.. → l2_resp same cycle, l2_rdata=0xA5..; ewb_yumi never asserted.
- EWB holds line 0x0000_4000 (hit), l2_read 0x0000_4010 → ewb_tag_check with ewb_tag=0x0000200; l2_resp exactly 2 cycles after request with hit data; no pmem_read.
- l2_read absent, EWB non-empty with head 0x8000_0040 → pmem_write addr 0x8000_0040 with head data; on pmem_resp, ewb_yumi one-cycle pulse; back to IDLE.
- ewb_full=1, miss to 0x0000_2000 → WRITE drains head first (one ewb_yumi), then CHECK again, then READ of 0x0000_2000.
- EWB non-empty, 5 back-to-back misses → first 4 go directly to pmem_read; 5th triggers one pmem_write before its read; streak resets to 0.
- Assert rst low mid-WRITE → pmem_write falls asynchronously, no ewb_yumi; after release, FSM re-drains the same head.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the L2 eviction write buffer / pmem arbiter.
package rv32i_types;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        FWD   = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } arb_state_t;

    // A cacheline is 32 bytes, so the low five address bits are the byte offset.
    localparam int LINE_OFFSET = 5;
    localparam int TAG_W       = 32 - LINE_OFFSET;

    // Line-aligned pmem address built from a line tag.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
        return {tag, {LINE_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/ewb_mem_arbiter.sv
// Arbitrates the single pmem port between L2 read misses and EWB drains,
// forwarding read misses straight from the EWB when the line is still queued.
//
// Handshakes: l2_read is a level request held until the one-cycle l2_resp;
// pmem_read/pmem_write are level requests held until the one-cycle pmem_resp;
// ewb_yumi is a one-cycle dequeue of the current EWB head, issued only in the
// cycle its write completes, so the head stays visible to lookups until then.
module ewb_mem_arbiter
    import rv32i_types::*;
#(
    parameter int WIDTH           = 256,
    parameter int MAX_READ_STREAK = 4,
    parameter int STREAK_W        = 3
) (
    input  logic             clk,
    input  logic             rst,

    // L2 cache controller
    input  logic             l2_read,
    input  logic [31:0]      l2_address,
    output logic [WIDTH-1:0] l2_rdata,
    output logic             l2_resp,

    // Eviction write buffer
    input  logic             ewb_empty,
    input  logic             ewb_full,
    input  logic [WIDTH-1:0] ewb_head_data,
    input  logic [31:0]      ewb_head_addr,
    output logic             ewb_yumi,
    output logic             ewb_tag_check,
    output logic [TAG_W-1:0] ewb_tag,
    input  logic             ewb_hit,
    input  logic [WIDTH-1:0] ewb_hit_data,

    // Physical memory / cacheline adaptor
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    input  logic [WIDTH-1:0] pmem_rdata,
    input  logic             pmem_resp,

    // Current FSM state, for observation only
    output arb_state_t       state_dbg
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_READ_STREAK);

    arb_state_t          state;
    arb_state_t          next_state;
    logic [TAG_W-1:0]    tag_q;
    logic [WIDTH-1:0]    hit_data_q;
    logic [STREAK_W-1:0] streak_q;
    logic                pending_rd_q;
    logic                miss_drain;

    // Byte-offset bits never reach pmem; they are deliberately dropped.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{l2_address[LINE_OFFSET-1:0],
                                  ewb_head_addr[LINE_OFFSET-1:0]};

    // A miss must drain first when the EWB is full, or when reads have
    // starved a non-empty EWB for the allowed number of consecutive reads.
    assign miss_drain = ewb_full || ((streak_q == STREAK_MAX) && !ewb_empty);

    assign state_dbg = state;

    // State register; reset drops any in-flight pmem request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; every output is zero unless its state drives it.
    always_comb begin
        next_state    = state;
        l2_rdata      = '0;
        l2_resp       = 1'b0;
        ewb_yumi      = 1'b0;
        ewb_tag_check = 1'b0;
        ewb_tag       = '0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = '0;
        pmem_wdata    = '0;

        unique case (state)
            IDLE: begin
                // Reads win over drains when both are possible.
                if (l2_read) begin
                    next_state = CHECK;
                end else if (!ewb_empty) begin
                    next_state = WRITE;
                end
            end

            CHECK: begin
                ewb_tag_check = 1'b1;
                ewb_tag       = tag_q;
                if (ewb_hit) begin
                    next_state = FWD;
                end else if (miss_drain) begin
                    next_state = WRITE;
                end else begin
                    next_state = READ;
                end
            end

            FWD: begin
                l2_resp    = 1'b1;
                l2_rdata   = hit_data_q;
                next_state = IDLE;
            end

            READ: begin
                pmem_read    = 1'b1;
                pmem_address = line_addr(tag_q);
                if (pmem_resp) begin
                    l2_resp    = 1'b1;
                    l2_rdata   = pmem_rdata;
                    next_state = IDLE;
                end
            end

            WRITE: begin
                pmem_write   = 1'b1;
                pmem_address = line_addr(ewb_head_addr[31:LINE_OFFSET]);
                pmem_wdata   = ewb_head_data;
                if (pmem_resp) begin
                    // Never dequeue from an empty buffer.
                    ewb_yumi = !ewb_empty;
                    // A deferred miss must look up again: another queued
                    // entry may still hold its line.
                    next_state = pending_rd_q ? CHECK : IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request tag, forwarded hit line and deferred-read flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q        <= '0;
            hit_data_q   <= '0;
            pending_rd_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (l2_read) begin
                        tag_q <= l2_address[31:LINE_OFFSET];
                    end
                end
                CHECK: begin
                    if (ewb_hit) begin
                        hit_data_q <= ewb_hit_data;
                    end else if (miss_drain) begin
                        pending_rd_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (pmem_resp && pending_rd_q) begin
                        pending_rd_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Consecutive pmem reads taken while the EWB holds data; any drain clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else if ((state == READ) && pmem_resp) begin
            if (ewb_empty) begin
                streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + 1'b1;
            end
        end else if ((state == WRITE) && pmem_resp) begin
            streak_q <= '0;
        end
    end

endmodule
